// File: rtl/csa_block_serial_adder.sv
// csa_block_serial_adder: serial carry-skip adder, one BLOCK-bit slice per cycle; clk/rst, a/b/cin in via in_valid/in_ready, sum/cout/skip_count out via out_valid/out_ready
module csa_block_serial_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  localparam int NBLK = WIDTH / BLOCK,
  localparam int CW = $clog2(NBLK + 1),
  localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CW-1:0]    skip_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry;
  logic [BW-1:0] blk;
  logic [BLOCK-1:0] a_s, b_s, rs;
  logic rc, p, bco, last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    last = blk == BW'(NBLK - 1);
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_comb begin
    a_s = BLOCK'(a_r >> (blk * BLOCK));
    b_s = BLOCK'(b_r >> (blk * BLOCK));
    {rc, rs} = {1'b0, a_s} + {1'b0, b_s} + {{BLOCK{1'b0}}, carry};
    p = &(a_s ^ b_s);
    bco = p ? carry : rc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      blk <= '0;
      sum <= '0;
      cout <= 1'b0;
      skip_count <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      carry <= cin;
      blk <= '0;
      sum <= '0;
      skip_count <= '0;
    end else if (state == RUN) begin
      sum[blk*BLOCK +: BLOCK] <= rs;
      carry <= bco;
      skip_count <= skip_count + CW'(p);
      blk <= last ? blk : blk + 1'b1;
      cout <= last ? bco : cout;
    end
endmodule

// File: tb/tb_csa_block_serial_adder.sv
// tb_csa_block_serial_adder: scoreboard bench for the serial carry-skip adder
module tb_csa_block_serial_adder;
  localparam int W = 16;
  localparam int BL = 4;
  localparam int NB = W / BL;
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic [2:0]   k;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 1, cout;
  logic [W-1:0] a = 0, b = 0, sum;
  logic [2:0] skip_count;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, sent = 0, got = 0;
  csa_block_serial_adder #(.WIDTH(W), .BLOCK(BL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .skip_count(skip_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] t;
    logic [W-1:0] pr;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    pr = x ^ y;
    e.s = t[W-1:0];
    e.c = t[W];
    e.k = 0;
    for (int i = 0; i < NB; i++) if (pr[i*BL +: BL] == {BL{1'b1}}) e.k++;
    return e;
  endfunction
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input exp_t e, input bit drop, output int acc);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      q.push_back(e);
      sent++;
    end
    if (drop) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask
  task automatic wait_out(output int at);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          got++;
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("skip_count", skip_count, e.k);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int acc, at, prev;
    logic [W-1:0] ta, tb;
    logic tc;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_skip", skip_count, 0);
    rst = 0;
    send(16'h1234, 16'h4321, 0, '{16'h5555, 1'b0, 3'd0}, 1, acc);
    wait_out(at);
    chk("latency", at - acc, NB + 1);
    send(16'hFFFF, 16'h0000, 1, '{16'h0000, 1'b1, 3'd4}, 1, acc);
    wait_out(at);
    send(16'h0F0F, 16'h00F0, 1, '{16'h1000, 1'b0, 3'd3}, 1, acc);
    wait_out(at);
    @(negedge clk);
    out_ready = 0;
    send(16'h8000, 16'h8000, 0, '{16'h0000, 1'b1, 3'd0}, 1, acc);
    wait_out(at);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", sum, 16'h0000);
      chk("hold_cout", cout, 1);
      chk("hold_skip", skip_count, 0);
      a = 16'h1111;
      in_valid = i == 2;
      @(negedge clk);
    end
    a = 16'h2222;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    chk("drop_valid", out_valid, 0);
    chk("no_capture_in_done", in_ready, 1);
    in_valid = 0;
    send(16'h0FFF, 16'h0000, 0, '{16'h0FFF, 1'b0, 3'd3}, 1, acc);
    @(negedge clk);
    rst = 1;
    #1;
    q.delete();
    sent--;
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_skip", skip_count, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    send(16'h0001, 16'h0001, 0, '{16'h0002, 1'b0, 3'd0}, 1, acc);
    wait_out(at);
    chk("latency_after_rst", at - acc, NB + 1);
    @(negedge clk);
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      ta = W'($urandom);
      tb = i % 4 == 0 ? ~ta ^ W'($urandom_range(0, 3) << 4) : W'($urandom);
      tc = 1'($urandom);
      send(ta, tb, tc, model(ta, tb, tc), 0, acc);
      if (i > 0) chk("throughput", acc - prev, NB + 2);
      prev = acc;
    end
    @(negedge clk);
    in_valid = 0;
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("result_count", got, sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
